// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM state encoding
// and the forward/reverse successor of each Gray-code state.
package encoder_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [2:0] {
    Q_INIT = 3'd0,
    Q_00   = 3'd1,
    Q_01   = 3'd2,
    Q_11   = 3'd3,
    Q_10   = 3'd4
  } quad_state_t;

  function automatic quad_state_t level_state(input logic [1:0] ab);
    quad_state_t s;
    case (ab)
      2'b00:   s = Q_00;
      2'b01:   s = Q_01;
      2'b11:   s = Q_11;
      2'b10:   s = Q_10;
      default: s = Q_INIT;
    endcase
    return s;
  endfunction

  // Forward rotation is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic quad_state_t fwd_next(input quad_state_t s);
    quad_state_t n;
    case (s)
      Q_00:    n = Q_10;
      Q_10:    n = Q_11;
      Q_11:    n = Q_01;
      Q_01:    n = Q_00;
      default: n = Q_INIT;
    endcase
    return n;
  endfunction

  function automatic quad_state_t rev_next(input quad_state_t s);
    quad_state_t n;
    case (s)
      Q_00:    n = Q_01;
      Q_01:    n = Q_11;
      Q_11:    n = Q_10;
      Q_10:    n = Q_00;
      default: n = Q_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/encoder_debounce.sv
// One encoder channel: two-flop synchronizer, consecutive-cycle debounce
// counter, filtered level and a valid bit set on the first accepted level.
module encoder_debounce
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic system_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_valid
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             w_pending;

  // Until the first acceptance, time a settled synchronizer pipe so that
  // a level equal to the reset value 0 can still be accepted.
  always_comb begin
    if (r_valid) begin
      w_pending = (r_sync2 != r_level);
    end else begin
      w_pending = (r_sync1 == r_sync2);
    end
  end

  always_ff @(posedge clock) begin
    if (system_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_pending) begin
        if (r_count == CNT_LAST) begin
          r_level <= r_sync2;
          r_valid <= 1'b1;
          r_count <= '0;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_valid = r_valid;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: debounced A/B channels feed a Gray-code step FSM that
// emits a tachometer strobe, direction, wrapping signed position and sticky error.
module quadrature_decoder
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int POS_WIDTH       = 32
) (
  input  logic                        clock,
  input  logic                        system_reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        clear_pos,
  input  logic                        err_clear,
  output logic                        pulse_out,
  output logic                        dir_out,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        err_out
);

  localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  logic                 w_level_a;
  logic                 w_valid_a;
  logic                 w_level_b;
  logic                 w_valid_b;
  quad_state_t          w_new_state;
  logic                 w_active;
  logic                 w_step_fwd;
  logic                 w_step_rev;
  logic                 w_illegal;

  quad_state_t          r_state;
  logic                 r_pulse;
  logic                 r_dir;
  logic                 r_err;
  logic [POS_WIDTH-1:0] r_pos;

  encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_a (
    .clock        (clock),
    .system_reset (system_reset),
    .i_raw        (enc_a),
    .o_level      (w_level_a),
    .o_valid      (w_valid_a)
  );

  encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_b (
    .clock        (clock),
    .system_reset (system_reset),
    .i_raw        (enc_b),
    .o_level      (w_level_b),
    .o_valid      (w_valid_b)
  );

  // A change landing right after a strobe is held off one cycle so strobes never abut.
  always_comb begin
    w_new_state = level_state({w_level_a, w_level_b});
    w_active    = (r_state != Q_INIT) && (w_new_state != r_state) && !r_pulse;
    w_step_fwd  = w_active && (w_new_state == fwd_next(r_state));
    w_step_rev  = w_active && (w_new_state == rev_next(r_state));
    w_illegal   = w_active && !w_step_fwd && !w_step_rev;
  end

  always_ff @(posedge clock) begin
    if (system_reset) begin
      r_state <= Q_INIT;
      r_pulse <= 1'b0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_pulse <= w_step_fwd | w_step_rev;
      if (r_state == Q_INIT) begin
        if (w_valid_a && w_valid_b) begin
          r_state <= w_new_state;
        end
      end else if (w_active) begin
        r_state <= w_new_state;
      end
      if (w_step_fwd | w_step_rev) begin
        r_dir <= w_step_fwd;
      end
      if (clear_pos) begin
        r_pos <= '0;
      end else if (w_step_fwd) begin
        r_pos <= r_pos + POS_ONE;
      end else if (w_step_rev) begin
        r_pos <= r_pos - POS_ONE;
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clear) begin
        r_err <= 1'b0;
      end
    end
  end

  assign pulse_out = r_pulse;
  assign dir_out   = r_dir;
  assign err_out   = r_err;
  assign position  = r_pos;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder with DEBOUNCE_CYCLES=4; a second
// 3-bit instance shares the inputs to exercise position wrap-around.
module tb_quadrature_decoder;

  localparam int D   = 4;
  localparam int LAT = D + 3;
  localparam int NW  = 3;

  logic clock        = 1'b0;
  logic system_reset = 1'b1;
  logic enc_a        = 1'b0;
  logic enc_b        = 1'b0;
  logic clear_pos    = 1'b0;
  logic err_clear    = 1'b0;
  logic pulse_out, dir_out, err_out;
  logic signed [31:0] position;
  logic pulse_n, dir_n, err_n;
  logic signed [NW-1:0] position_n;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulse_log[$];
  int exp_pulses[$];
  longint model_pos = 0;
  bit model_dir = 1'b0;
  logic [1:0] ab = 2'b00;
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quadrature_decoder #(.DEBOUNCE_CYCLES(D), .POS_WIDTH(32)) dut (
    .clock(clock), .system_reset(system_reset), .enc_a(enc_a), .enc_b(enc_b),
    .clear_pos(clear_pos), .err_clear(err_clear), .pulse_out(pulse_out),
    .dir_out(dir_out), .position(position), .err_out(err_out)
  );

  quadrature_decoder #(.DEBOUNCE_CYCLES(D), .POS_WIDTH(NW)) dut_n (
    .clock(clock), .system_reset(system_reset), .enc_a(enc_a), .enc_b(enc_b),
    .clear_pos(clear_pos), .err_clear(err_clear), .pulse_out(pulse_n),
    .dir_out(dir_n), .position(position_n), .err_out(err_n)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;
  always @(negedge clock) if (pulse_out === 1'b1) pulse_log.push_back(cyc);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic string q_str(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic int idx_of(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_ab(input logic [1:0] v);
    ab = v;
    enc_a = v[1];
    enc_b = v[0];
  endtask

  // One Gray-code step; the strobe is expected D+3 edges after the drive.
  task automatic do_step(input bit fwd);
    int i;
    i = idx_of(ab);
    drive_ab(seq[fwd ? (i + 1) % 4 : (i + 3) % 4]);
    exp_pulses.push_back(cyc + LAT);
    model_pos = model_pos + (fwd ? 64'sd1 : -64'sd1);
    model_dir = fwd;
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(negedge clock);
    drive_ab(v);
    system_reset = 1'b1;
    clear_pos = 1'b0;
    err_clear = 1'b0;
    wait_cycles(3);
    pulse_log.delete();
    exp_pulses.delete();
    model_pos = 0;
    model_dir = 1'b0;
    system_reset = 1'b0;
    wait_cycles(14);
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    do_step(1'b1);
    wait_cycles(LAT + 2);
    n_checks++; if (position !== 32'sd1) $display("FAIL rst_pre_pos: got %0d expected 1", position); else n_pass++;
    system_reset = 1'b1;
    wait_cycles(2);
    n_checks++; if (pulse_out !== 1'b0) $display("FAIL rst_pulse: got %b expected 0", pulse_out); else n_pass++;
    n_checks++; if (dir_out !== 1'b0) $display("FAIL rst_dir: got %b expected 0", dir_out); else n_pass++;
    n_checks++; if (position !== 32'sd0) $display("FAIL rst_pos: got %0d expected 0", position); else n_pass++;
    n_checks++; if (err_out !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_out); else n_pass++;
  endtask

  task automatic test_init_11();
    do_reset(2'b11);
    n_checks++; if (pulse_log.size() != 0) $display("FAIL init11_pulses: got %0d pulses expected 0", pulse_log.size()); else n_pass++;
    n_checks++; if ({err_out, position} !== 33'd0) $display("FAIL init11_err_pos: got err=%b pos=%0d expected 0/0", err_out, position); else n_pass++;
    do_step(1'b1);
    wait_cycles(LAT + 3);
    n_checks++; if (q_str(pulse_log) != q_str(exp_pulses)) $display("FAIL init11_step: got [%s] expected [%s]", q_str(pulse_log), q_str(exp_pulses)); else n_pass++;
    n_checks++; if (dir_out !== model_dir || position !== 32'(model_pos)) $display("FAIL init11_dirpos: got dir=%b pos=%0d expected %b/%0d", dir_out, position, model_dir, 32'(model_pos)); else n_pass++;
  endtask

  task automatic test_forward_four();
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      do_step(1'b1);
      wait_cycles(20);
    end
    n_checks++; if (q_str(pulse_log) != q_str(exp_pulses)) $display("FAIL fwd4_pulses: got [%s] expected [%s]", q_str(pulse_log), q_str(exp_pulses)); else n_pass++;
    n_checks++; if (position !== 32'(model_pos)) $display("FAIL fwd4_pos: got %0d expected %0d", position, 32'(model_pos)); else n_pass++;
    n_checks++; if (dir_out !== 1'b1) $display("FAIL fwd4_dir: got %b expected 1", dir_out); else n_pass++;
  endtask

  task automatic test_glitch();
    int c0;
    do_reset(2'b00);
    enc_a = 1'b1;
    wait_cycles(D - 1);
    enc_a = 1'b0;
    wait_cycles(20);
    n_checks++; if (pulse_log.size() != 0 || position !== 32'sd0) $display("FAIL glitch_short: got %0d pulses pos=%0d expected 0/0", pulse_log.size(), position); else n_pass++;
    c0 = cyc;
    do_step(1'b1);
    wait_cycles(D);
    do_step(1'b0);
    wait_cycles(c0 + LAT - cyc);
    n_checks++; if (pulse_out !== 1'b1 || position !== 32'sd1) $display("FAIL glitch_accept: got pulse=%b pos=%0d expected 1/1", pulse_out, position); else n_pass++;
    wait_cycles(15);
    n_checks++; if (q_str(pulse_log) != q_str(exp_pulses)) $display("FAIL glitch_pulses: got [%s] expected [%s]", q_str(pulse_log), q_str(exp_pulses)); else n_pass++;
    n_checks++; if (dir_out !== model_dir || position !== 32'(model_pos)) $display("FAIL glitch_end: got dir=%b pos=%0d expected %b/%0d", dir_out, position, model_dir, 32'(model_pos)); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset(2'b00);
    for (int i = 0; i < 3; i++) begin
      do_step(1'b1);
      wait_cycles(12);
    end
    n_checks++; if (position_n !== NW'(model_pos)) $display("FAIL wrap_max: got %b expected %b", position_n, NW'(model_pos)); else n_pass++;
    do_step(1'b1);
    wait_cycles(12);
    n_checks++; if (position_n !== 3'b100) $display("FAIL wrap_min: got %b expected 100", position_n); else n_pass++;
    clear_pos = 1'b1;
    wait_cycles(1);
    clear_pos = 1'b0;
    model_pos = 0;
    wait_cycles(2);
    n_checks++; if (position !== 32'sd0 || position_n !== 3'b000) $display("FAIL wrap_clear: got %0d/%b expected 0/000", position, position_n); else n_pass++;
    do_step(1'b0);
    wait_cycles(12);
    n_checks++; if (position !== 32'(model_pos)) $display("FAIL wrap_neg: got %h expected %h", position, 32'(model_pos)); else n_pass++;
    n_checks++; if (position_n !== 3'b111) $display("FAIL wrap_neg_n: got %b expected 111", position_n); else n_pass++;
    n_checks++; if (dir_out !== 1'b0) $display("FAIL wrap_dir: got %b expected 0", dir_out); else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset(2'b00);
    do_step(1'b1);
    wait_cycles(LAT + 3);
    drive_ab(2'b01);
    wait_cycles(LAT + 2);
    n_checks++; if (err_out !== 1'b1) $display("FAIL illegal_err: got %b expected 1", err_out); else n_pass++;
    n_checks++; if (position !== 32'(model_pos) || dir_out !== model_dir) $display("FAIL illegal_hold: got pos=%0d dir=%b expected %0d/%b", position, dir_out, 32'(model_pos), model_dir); else n_pass++;
    n_checks++; if (q_str(pulse_log) != q_str(exp_pulses)) $display("FAIL illegal_pulses: got [%s] expected [%s]", q_str(pulse_log), q_str(exp_pulses)); else n_pass++;
    err_clear = 1'b1;
    wait_cycles(1);
    err_clear = 1'b0;
    wait_cycles(2);
    n_checks++; if (err_out !== 1'b0) $display("FAIL illegal_clear: got %b expected 0", err_out); else n_pass++;
    drive_ab(2'b10);
    wait_cycles(D + 2);
    err_clear = 1'b1;
    wait_cycles(1);
    err_clear = 1'b0;
    wait_cycles(2);
    n_checks++; if (err_out !== 1'b1) $display("FAIL illegal_coincident: got %b expected 1", err_out); else n_pass++;
  endtask

  task automatic test_clear_coincident();
    do_reset(2'b00);
    do_step(1'b1);
    wait_cycles(LAT + 3);
    do_step(1'b1);
    wait_cycles(D + 2);
    clear_pos = 1'b1;
    wait_cycles(1);
    clear_pos = 1'b0;
    model_pos = 0;
    n_checks++; if (pulse_out !== 1'b1 || position !== 32'sd0) $display("FAIL clr_coinc: got pulse=%b pos=%0d expected 1/0", pulse_out, position); else n_pass++;
    n_checks++; if (dir_out !== 1'b1) $display("FAIL clr_dir: got %b expected 1", dir_out); else n_pass++;
  endtask

  task automatic test_reset_mid_step();
    do_reset(2'b00);
    drive_ab(2'b10);
    wait_cycles(D);
    system_reset = 1'b1;
    wait_cycles(3);
    system_reset = 1'b0;
    wait_cycles(25);
    n_checks++; if (pulse_log.size() != 0) $display("FAIL rst_mid_pulses: got %0d pulses expected 0", pulse_log.size()); else n_pass++;
    n_checks++; if (position !== 32'sd0 || err_out !== 1'b0) $display("FAIL rst_mid_state: got pos=%0d err=%b expected 0/0", position, err_out); else n_pass++;
  endtask

  task automatic test_random();
    int L;
    do_reset(2'b00);
    for (int s = 0; s < 30; s++) begin
      do_step(1'($urandom_range(1, 0)));
      wait_cycles(LAT + 1);
      n_checks++; if (position !== 32'(model_pos)) $display("FAIL rand_pos%0d: got %0d expected %0d", s, position, 32'(model_pos)); else n_pass++;
      if ($urandom_range(1, 0) == 1) begin
        L = $urandom_range(D - 1, 1);
        if ($urandom_range(1, 0) == 1) begin
          enc_a = ~enc_a;
          wait_cycles(L);
          enc_a = ~enc_a;
        end else begin
          enc_b = ~enc_b;
          wait_cycles(L);
          enc_b = ~enc_b;
        end
      end
      wait_cycles(2 + $urandom_range(5, 0));
    end
    wait_cycles(15);
    n_checks++; if (q_str(pulse_log) != q_str(exp_pulses)) $display("FAIL rand_pulses: got [%s] expected [%s]", q_str(pulse_log), q_str(exp_pulses)); else n_pass++;
    n_checks++; if (dir_out !== model_dir) $display("FAIL rand_dir: got %b expected %b", dir_out, model_dir); else n_pass++;
    n_checks++; if (position_n !== NW'(model_pos)) $display("FAIL rand_pos_n: got %b expected %b", position_n, NW'(model_pos)); else n_pass++;
    n_checks++; if (err_out !== 1'b0) $display("FAIL rand_err: got %b expected 0", err_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_11();
    test_forward_four();
    test_glitch();
    test_wrap();
    test_illegal();
    test_clear_coincident();
    test_reset_mid_step();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
